universal_shift_reg: RTL
========================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised universal register: WIDTH flip-flops sharing one clock, with
//  hold, shift-right, shift-left and parallel-load modes, per 74x194.
//  Successor to the single-bit D flip-flop. Adds width, synchronous reset,
//  clock enable, serial chaining and an optional rotate mode.
//  Sits in datapath labs as an accumulator, serialiser or deserialiser and
//  ring counter. Drives both true and complemented outputs.
// PARAMETERS
//  WIDTH      4    number of bits; legal range 2..32
//  RESET_VAL  0    WIDTH-bit value loaded into q on reset
//  ROTATE     0    1: shift modes wrap end bits; sr_in/sl_in ignored
// PORTS
//  clk     in   1      single clock; all state updates on rising edge
//  rst     in   1      synchronous, active-high reset
//  en      in   1      clock enable; 0 = hold regardless of mode
//  mode    in   2      00 hold, 01 shift right, 10 shift left, 11 load
//  sr_in   in   1      serial input entering at MSB on shift right
//  sl_in   in   1      serial input entering at LSB on shift left
//  d       in   WIDTH  parallel load data
//  q       out  WIDTH  register contents
//  nq      out  WIDTH  bitwise complement of q
// BEHAVIOUR
//  - Reset: q and nq are registered outputs.
//    On a rising edge with rst=1: q=RESET_VAL and nq=~RESET_VAL.
//    rst takes priority over en and mode.
//  - Priority at each edge: rst, then en=0 (hold), then mode.
//  - mode 00: q unchanged.
//  - mode 01: q <= {sr_in, q[WIDTH-1:1]}.
//    If ROTATE=1: q <= {q[0], q[WIDTH-1:1]}.
//  - mode 10: q <= {q[WIDTH-2:0], sl_in}.
//    If ROTATE=1: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
//  - mode 11: q <= d.
//  - Latency: one cycle; the new q is visible after the edge that samples the inputs.
//  - nq == ~q at all times, including immediately after reset. No cycle may show
//    q and nq equal.
//  - Serial chaining: q[0] is the shift-right serial out; q[WIDTH-1] is the
//    shift-left serial out. No extra ports.
//  - Inputs change only between edges. Asynchronous behaviour is not specified.
//  - Reset asserted mid-shift discards the shift. The operation does not resume.
//  - Before the first reset, q is X; benches must reset first.
// STRUCTURE
//  - Shared package/header: mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01,
//    MODE_SHL=2'b10, MODE_LOAD=2'b11.
//  - Sub-module usr_cell: one bit.
//    Contains a 4:1 next-state mux (hold/right neighbour/left neighbour/d).
//    Also contains the rst/en gating and a positive-edge D flip-flop with q/nq.
//  - Top: generate loop of WIDTH usr_cell instances.
//    Neighbour wiring: end cells select sr_in/sl_in, or the opposite end bit
//    when ROTATE=1.
// TESTING
//  1 WIDTH=4, RESET_VAL=4'b1010: pulse rst -> q=1010, nq=0101.
//    Then en=0 with mode=11, d=1111 for 3 cycles -> q stays 1010.
//  2 Load then hold: en=1, mode=11, d=0110 -> next cycle q=0110.
//    Then mode=00 for 2 cycles -> q=0110.
//  3 Shift right: q=0110, mode=01, sr_in=1 -> q=1011 after one edge,
//    then 1101 after the next edge.
//  4 Shift left: q=0110, mode=10, sl_in=0 -> 1100 after one edge,
//    1000 after the next edge.
//  5 ROTATE=1 ring counter: load 0001.
//    mode=10 for 4 cycles -> 0010, 0100, 1000, 0001; sl_in toggling has no effect.
//  6 Reset mid-operation: shifting with mode=01, assert rst for one edge.
//    -> q=RESET_VAL next cycle.
//    Deassert rst -> shifting restarts from RESET_VAL.
//    Check nq==~q on every cycle of all tests.

Source files
------------

// File: rtl/universal_shift_reg_pkg.sv
// Shared mode encodings for the universal shift register and its bit cells.
package universal_shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/universal_shift_reg_cell.sv
// One register bit: 4:1 next-state mux, rst/en gating, and a flop pair
// holding q and its complement so nq is never a cycle behind q.
module usr_cell
  import universal_shift_reg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_e mode,
  input  logic  rnb,
  input  logic  lnb,
  input  logic  d,
  output logic  q,
  output logic  nq
);

  logic nxt;

  always_comb begin
    nxt = q;
    case (mode)
      MODE_HOLD: nxt = q;
      MODE_SHR:  nxt = rnb;
      MODE_SHL:  nxt = lnb;
      MODE_LOAD: nxt = d;
      default:   nxt = q;
    endcase
  end

  // nq gets its own flop loaded with the complement, keeping both outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= RST_BIT;
      nq <= ~RST_BIT;
    end else if (en) begin
      q  <= nxt;
      nq <= ~nxt;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// 74x194-style universal register: WIDTH bit cells with neighbour wiring,
// serial in at the ends, or wrap-around when ROTATE is set.
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ROTATE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq
);

  logic [WIDTH-1:0] rnb;
  logic [WIDTH-1:0] lnb;
  mode_e            mode_q;

  assign mode_q = mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // rnb feeds shift right (bit moves down), lnb feeds shift left.
    if (i == WIDTH-1) begin : g_msb
      assign rnb[i] = ROTATE ? q[0] : sr_in;
    end else begin : g_rmid
      assign rnb[i] = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign lnb[i] = ROTATE ? q[WIDTH-1] : sl_in;
    end else begin : g_lmid
      assign lnb[i] = q[i-1];
    end

    usr_cell #(
      .RST_BIT (RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode_q),
      .rnb  (rnb[i]),
      .lnb  (lnb[i]),
      .d    (d[i]),
      .q    (q[i]),
      .nq   (nq[i])
    );
  end

endmodule
